// File: rtl/extend_sector_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : extend_sector_cnt_pkg
//  Description : Shared widths, defaults and channel index helper for the
//                counter-based sector hit extender.
//  Revision    : 1.0  initial release
// ============================================================================
package extend_sector_cnt_pkg;

    localparam int c_ph_raw_w  = 6;
    localparam int c_max_drift = 7;
    localparam int c_dt_w      = 3;

    // Flat channel number used by ch_en and busy; stations are numbered from 1.
    function automatic int ch_idx(input int zone, input int station, input int stations);
        return zone * stations + (station - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/extend_sector_cnt_if.sv
`default_nettype none
// ============================================================================
//  Module      : extend_sector_cnt_if
//  Description : Hit and control bundle between zone ph formation and the
//                extender, plus the extended hits returned to the matcher.
//  Revision    : 1.0  initial release
// ============================================================================
interface extend_sector_cnt_if
    import extend_sector_cnt_pkg::*;
#(
    parameter int ZONES    = 4,
    parameter int STATIONS = 4,
    parameter int BIT_W    = c_ph_raw_w,
    parameter int DT_W     = c_dt_w
);
    logic [BIT_W-1:0]          ph_zone [ZONES-1:0][STATIONS:1];
    logic [DT_W-1:0]           drifttime;
    logic                      retrig;
    logic [ZONES*STATIONS-1:0] ch_en;
    logic [BIT_W-1:0]          ph_ext  [ZONES-1:0][STATIONS:1];
    logic [ZONES*STATIONS-1:0] busy;

    modport master (
        output ph_zone, drifttime, retrig, ch_en,
        input  ph_ext, busy
    );

    modport slave (
        input  ph_zone, drifttime, retrig, ch_en,
        output ph_ext, busy
    );
endinterface
`default_nettype wire

// File: rtl/extend_sector_cnt_extender_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : extender_cnt
//  Description : One channel of BIT_W independent hit stretchers, each a
//                down-counter with retrigger or dead-time behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module extender_cnt #(
    parameter int BIT_W     = 6,
    parameter int MAX_DRIFT = 7,
    parameter int DTE_W     = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [BIT_W-1:0] inp,
    input  wire logic             en,
    input  wire logic             retrig,
    input  wire logic [DTE_W-1:0] dt_eff,
    output logic      [BIT_W-1:0] outp,
    output logic                  busy
);
    localparam int c_cnt_w = ($clog2(MAX_DRIFT) < 1) ? 1 : $clog2(MAX_DRIFT);

    logic [c_cnt_w-1:0] r_cnt     [BIT_W];
    logic [c_cnt_w-1:0] w_cnt_nxt [BIT_W];
    logic [c_cnt_w-1:0] w_load_val;
    logic [BIT_W-1:0]   w_ext_nxt;
    logic [BIT_W-1:0]   r_ext;
    logic               r_busy;

    // The counter holds the number of cycles left after the current one, so
    // a load of dt_eff-1 yields exactly dt_eff high cycles.
    always_comb begin
        w_load_val = c_cnt_w'(dt_eff - 1'b1);
        w_ext_nxt  = '0;
        for (int b = 0; b < BIT_W; b++) begin
            w_cnt_nxt[b] = '0;
            if (inp[b] && en && (retrig || (r_cnt[b] == '0))) begin
                w_cnt_nxt[b] = w_load_val;
                w_ext_nxt[b] = 1'b1;
            end else if (r_cnt[b] != '0) begin
                w_cnt_nxt[b] = r_cnt[b] - 1'b1;
                w_ext_nxt[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '{default: '0};
            r_ext  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ext  <= w_ext_nxt;
            r_busy <= |w_ext_nxt;
        end
    end

    assign outp = r_ext;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/extend_sector_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : extend_sector_cnt
//  Description : Per-sector raw-hit extender with programmable length,
//                retrigger/dead-time mode, channel enables and busy flags.
//  Revision    : 1.0  initial release
// ============================================================================
module extend_sector_cnt
    import extend_sector_cnt_pkg::*;
#(
    parameter int ZONES     = 4,
    parameter int STATIONS  = 4,
    parameter int BIT_W     = c_ph_raw_w,
    parameter int MAX_DRIFT = c_max_drift,
    parameter int DT_W      = c_dt_w
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    extend_sector_cnt_if.slave bus
);
    // Wide enough for both the raw drifttime and the value MAX_DRIFT itself.
    localparam int c_dte_w = (DT_W > $clog2(MAX_DRIFT + 1)) ? DT_W : $clog2(MAX_DRIFT + 1);

    logic [c_dte_w-1:0] w_dt_ext;
    logic [c_dte_w-1:0] w_dt_eff;

    always_comb begin
        w_dt_ext = c_dte_w'(bus.drifttime);
        w_dt_eff = w_dt_ext;
        if (w_dt_ext == '0) begin
            w_dt_eff = c_dte_w'(1);
        end else if (w_dt_ext > c_dte_w'(MAX_DRIFT)) begin
            w_dt_eff = c_dte_w'(MAX_DRIFT);
        end
    end

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        for (genvar s = 1; s <= STATIONS; s++) begin : g_station
            localparam int c_idx = ch_idx(z, s, STATIONS);

            logic [BIT_W-1:0] w_ext;
            logic             w_busy;

            extender_cnt #(
                .BIT_W     (BIT_W),
                .MAX_DRIFT (MAX_DRIFT),
                .DTE_W     (c_dte_w)
            ) u_extender (
                .clk    (clk),
                .rst_n  (rst_n),
                .inp    (bus.ph_zone[z][s]),
                .en     (bus.ch_en[c_idx]),
                .retrig (bus.retrig),
                .dt_eff (w_dt_eff),
                .outp   (w_ext),
                .busy   (w_busy)
            );

            assign bus.ph_ext[z][s]  = w_ext;
            assign bus.busy[c_idx]   = w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_extend_sector_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_extend_sector_cnt
//  Description : Bench for extend_sector_cnt, two instances (MAX_DRIFT 7 and 5)
//                sharing one stimulus, checked against a window-end-time model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_extend_sector_cnt;
    import extend_sector_cnt_pkg::*;

    localparam int ZONES    = 4;
    localparam int STATIONS = 4;
    localparam int NCH      = ZONES * STATIONS;
    localparam int BW       = c_ph_raw_w;
    localparam int DT_W     = c_dt_w;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0]   ph_zone [ZONES-1:0][STATIONS:1];
    logic [DT_W-1:0] drifttime;
    logic            retrig;
    logic [NCH-1:0]  ch_en;

    extend_sector_cnt_if #(.ZONES(ZONES), .STATIONS(STATIONS), .BIT_W(BW), .DT_W(DT_W)) bus_a ();
    extend_sector_cnt_if #(.ZONES(ZONES), .STATIONS(STATIONS), .BIT_W(BW), .DT_W(DT_W)) bus_b ();

    assign bus_a.ph_zone   = ph_zone;
    assign bus_a.drifttime = drifttime;
    assign bus_a.retrig    = retrig;
    assign bus_a.ch_en     = ch_en;
    assign bus_b.ph_zone   = ph_zone;
    assign bus_b.drifttime = drifttime;
    assign bus_b.retrig    = retrig;
    assign bus_b.ch_en     = ch_en;

    extend_sector_cnt #(
        .ZONES(ZONES), .STATIONS(STATIONS), .BIT_W(BW), .MAX_DRIFT(7), .DT_W(DT_W)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    extend_sector_cnt #(
        .ZONES(ZONES), .STATIONS(STATIONS), .BIT_W(BW), .MAX_DRIFT(5), .DT_W(DT_W)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Model: each bit remembers the last edge number whose following cycle is
    // still inside its window; the output after edge t is high iff t <= end.
    int t = 0;
    int end_t [2][NCH][BW];
    int maxd  [2] = '{7, 5};
    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    function automatic int dt_eff_of(input int dt, input int mx);
        if (dt < 1) return 1;
        if (dt > mx) return mx;
        return dt;
    endfunction

    function automatic logic exp_bit(input int d, input int c, input int b);
        return t <= end_t[d][c][b];
    endfunction

    function automatic logic [BW-1:0] dut_ext(input int d, input int z, input int s);
        return (d == 0) ? bus_a.ph_ext[z][s] : bus_b.ph_ext[z][s];
    endfunction

    function automatic logic [NCH-1:0] dut_busy(input int d);
        return (d == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    always @(posedge clk) begin
        t = t + 1;
        for (int d = 0; d < 2; d++)
            for (int z = 0; z < ZONES; z++)
                for (int s = 1; s <= STATIONS; s++)
                    for (int b = 0; b < BW; b++) begin
                        int c;
                        c = z * STATIONS + s - 1;
                        if (!rst_n)
                            end_t[d][c][b] = -1;
                        else if (ph_zone[z][s][b] && ch_en[c] && (retrig || t > end_t[d][c][b]))
                            end_t[d][c][b] = t + dt_eff_of(int'(drifttime), maxd[d]) - 1;
                    end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [NCH-1:0] exp_busy;
                logic [NCH-1:0] got_busy;
                exp_busy = '0;
                for (int z = 0; z < ZONES; z++)
                    for (int s = 1; s <= STATIONS; s++) begin
                        logic [BW-1:0] e;
                        logic [BW-1:0] g;
                        int c;
                        c = z * STATIONS + s - 1;
                        for (int b = 0; b < BW; b++) e[b] = exp_bit(d, c, b);
                        exp_busy[c] = |e;
                        g = dut_ext(d, z, s);
                        checks++;
                        if (g !== e) begin
                            failures++;
                            $display("FAIL ph_ext dut%0d z%0d s%0d edge %0d: got %b want %b", d, z, s, t, g, e);
                        end
                    end
                got_busy = dut_busy(d);
                checks++;
                if (got_busy !== exp_busy) begin
                    failures++;
                    $display("FAIL busy dut%0d edge %0d: got %h want %h", d, t, got_busy, exp_busy);
                end
            end
        end
    end

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_inputs();
        for (int z = 0; z < ZONES; z++)
            for (int s = 1; s <= STATIONS; s++)
                ph_zone[z][s] = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
    endtask

    // Drive one bit with in_m[i] for cycle i and pin the DUT output, busy flag
    // and model prediction to exp_m[i]. drifttime switches to dt2 at cycle 1;
    // the channel is disabled from cycle en_off_at on (never if negative).
    task automatic run_seq(input string name, input int d, input int z, input int s, input int b,
                           input int dt1, input int dt2, input logic rt, input int en_off_at,
                           input logic [31:0] in_m, input logic [31:0] exp_m, input int n);
        int c;
        logic [BW-1:0]  g;
        logic [NCH-1:0] gb;
        c = z * STATIONS + s - 1;
        retrig    = rt;
        drifttime = DT_W'(dt1);
        for (int i = 0; i < n; i++) begin
            if (i == 1) drifttime = DT_W'(dt2);
            if (en_off_at >= 0 && i >= en_off_at) ch_en[c] = 1'b0;
            ph_zone[z][s][b] = in_m[i];
            @(negedge clk);
            g  = dut_ext(d, z, s);
            gb = dut_busy(d);
            pin($sformatf("%s out[%0d]", name, i), int'(g[b]), int'(exp_m[i]));
            pin($sformatf("%s busy[%0d]", name, i), int'(gb[c]), int'(exp_m[i]));
            pin($sformatf("%s model[%0d]", name, i), int'(exp_bit(d, c, b)), int'(exp_m[i]));
        end
        ch_en = '1;
        retrig = 1'b1;
        idle(10);
    endtask

    function automatic int any_out(input int d);
        logic acc;
        acc = |dut_busy(d);
        for (int z = 0; z < ZONES; z++)
            for (int s = 1; s <= STATIONS; s++)
                acc = acc | (|dut_ext(d, z, s));
        return int'(acc);
    endfunction

    function automatic int all_out(input int d);
        logic acc;
        acc = &dut_busy(d);
        for (int z = 0; z < ZONES; z++)
            for (int s = 1; s <= STATIONS; s++)
                acc = acc & (&dut_ext(d, z, s));
        return int'(acc);
    endfunction

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++)
                for (int b = 0; b < BW; b++)
                    end_t[d][c][b] = -1;
        clear_inputs();
        drifttime = 3'd3;
        retrig    = 1'b1;
        ch_en     = '1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        pin("reset dut0", any_out(0), 0);
        pin("reset dut1", any_out(1), 0);
        idle(5);

        run_seq("single",      0, 0, 1, 5, 3, 3, 1'b1, -1, 32'b1,       32'b0111,      5);
        run_seq("retrig",      0, 0, 1, 0, 4, 4, 1'b1, -1, 32'b101,     32'b0111111,   8);
        run_seq("deadtime",    0, 0, 1, 0, 4, 4, 1'b0, -1, 32'b101,     32'b00001111,  8);
        run_seq("dt0",         0, 1, 2, 3, 0, 0, 1'b1, -1, 32'b1,       32'b001,       3);
        run_seq("clamp5",      1, 2, 3, 1, 7, 7, 1'b1, -1, 32'b1,       32'b0011111,   7);
        run_seq("dt7",         0, 2, 3, 1, 7, 7, 1'b1, -1, 32'b1,       32'b001111111, 9);
        run_seq("dtchange",    0, 3, 4, 4, 2, 6, 1'b1, -1, 32'b1,       32'b0011,      4);
        run_seq("disabled",    0, 0, 4, 2, 4, 4, 1'b1,  0, 32'b1,       32'b000,       3);
        run_seq("en_drop",     0, 0, 1, 2, 4, 4, 1'b1,  1, 32'b111,     32'b001111,    6);
        run_seq("level_rt",    0, 1, 1, 0, 3, 3, 1'b1, -1, 32'b1111,    32'b00111111,  8);
        run_seq("level_dead",  0, 1, 1, 0, 3, 3, 1'b0, -1, 32'b1111111, 32'b00111111111, 11);

        // Reset in the third output cycle of a full-width burst.
        drifttime = 3'd7;
        for (int z = 0; z < ZONES; z++)
            for (int s = 1; s <= STATIONS; s++)
                ph_zone[z][s] = '1;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        pin("burst full dut0", all_out(0), 1);
        pin("burst full dut1", all_out(1), 1);
        rst_n = 1'b0;
        @(negedge clk);
        pin("reset cut dut0", any_out(0), 0);
        pin("reset cut dut1", any_out(1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pin("post reset dut0", any_out(0), 0);
        pin("post reset dut1", any_out(1), 0);
        idle(3);

        for (int i = 0; i < 10000; i++) begin
            for (int z = 0; z < ZONES; z++)
                for (int s = 1; s <= STATIONS; s++)
                    if ($urandom_range(0, 3) == 0)
                        ph_zone[z][s] = BW'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) drifttime = DT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) retrig = ~retrig;
            if ($urandom_range(0, 31) == 0) ch_en = NCH'($urandom | $urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end

        rst_n = 1'b1;
        idle(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
